// File: rtl/sstl_bidir_pkg.sv
// Shared definitions for the SSTL bidirectional pad controller:
// the controller state encoding, counter widths and legal parameter ranges.
package sstl_bidir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_TURN    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    // Turnaround/sample counter and burst counter widths.
    localparam int CNT_W   = 4;
    localparam int BURST_W = 8;

    // Legal parameter ranges, checked at elaboration by the top level.
    localparam int TURN_MIN   = 1;
    localparam int TURN_MAX   = 15;
    localparam int SAMPLE_MIN = 1;
    localparam int SAMPLE_MAX = 15;
    localparam int BURST_MIN  = 1;
    localparam int BURST_MAX  = 255;

    // Burst count saturates here rather than wrapping.
    localparam logic [BURST_W-1:0] BURST_SAT = '1;

endpackage

// File: rtl/sstl_bidir_cnt.sv
// Loadable down-counter shared by the TURN and CAPTURE phases.
// Loaded with N on phase entry; done is high during the N-th cycle of the phase.
module sstl_bidir_cnt
    import sstl_bidir_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Load on phase entry, otherwise count down while the phase runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign done = (count == CNT_W'(1));

endmodule

// File: rtl/sstl_bidir_ctrl.sv
// Half-duplex controller for an SSTL3 class II DCI bidirectional pad buffer.
// Drives the buffer's I/T pins from a valid/ready transmit stream, samples O
// on request, and inserts hi-Z turnaround gaps between every drive and capture.
module sstl_bidir_ctrl
    import sstl_bidir_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int TURN_CYC   = 2,
    parameter int SAMPLE_DLY = 3,
    parameter int MAX_BURST  = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] TX_DATA,
    input  logic             TX_VALID,
    output logic             TX_READY,
    input  logic             RX_REQ,
    output logic [WIDTH-1:0] RX_DATA,
    output logic             RX_VALID,
    output logic [WIDTH-1:0] PAD_I,
    output logic             PAD_T,
    input  logic [WIDTH-1:0] PAD_O,
    output logic             BUSY,
    output logic [1:0]       DBG_STATE
);

    if (TURN_CYC < TURN_MIN || TURN_CYC > TURN_MAX) begin : g_turn_range
        $error("sstl_bidir_ctrl: TURN_CYC out of range 1..15");
    end
    if (SAMPLE_DLY < SAMPLE_MIN || SAMPLE_DLY > SAMPLE_MAX) begin : g_sample_range
        $error("sstl_bidir_ctrl: SAMPLE_DLY out of range 1..15");
    end
    if (MAX_BURST < BURST_MIN || MAX_BURST > BURST_MAX) begin : g_burst_range
        $error("sstl_bidir_ctrl: MAX_BURST out of range 1..255");
    end
    if (WIDTH < 1) begin : g_width_range
        $error("sstl_bidir_ctrl: WIDTH must be at least 1");
    end

    localparam logic [CNT_W-1:0]   TURN_LD   = CNT_W'(TURN_CYC);
    localparam logic [CNT_W-1:0]   SAMPLE_LD = CNT_W'(SAMPLE_DLY);
    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_BURST);

    state_t             state;
    logic               rx_pend;
    logic [BURST_W-1:0] burst_cnt;
    logic               tx_fire;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_en;
    logic               cnt_done;

    // Handshake: a word transfers on a rising edge where TX_VALID and TX_READY
    // are both high. TX_READY never depends on TX_VALID, and TX_VALID may drop
    // at any time. Ready is offered in IDLE with no read pending, and in DRIVE
    // until a pending read has waited MAX_BURST words; it is held low in reset.
    always_comb begin
        TX_READY = 1'b0;
        if (!RST) begin
            case (state)
                ST_IDLE:  TX_READY = !rx_pend;
                ST_DRIVE: TX_READY = !(rx_pend && (burst_cnt >= BURST_LIM));
                default:  TX_READY = 1'b0;
            endcase
        end
    end

    assign tx_fire = TX_VALID && TX_READY;

    // Load the shared counter on entry to TURN (from DRIVE or CAPTURE) or CAPTURE.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = TURN_LD;
        case (state)
            ST_IDLE: begin
                if (rx_pend) begin
                    cnt_load = 1'b1;
                    cnt_val  = SAMPLE_LD;
                end
            end
            ST_DRIVE:   cnt_load = !tx_fire;
            ST_CAPTURE: cnt_load = cnt_done;
            default:    cnt_load = 1'b0;
        endcase
    end

    assign cnt_en = (state == ST_TURN) || (state == ST_CAPTURE);

    sstl_bidir_cnt u_cnt (
        .clk      (CLK),
        .rst      (RST),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .done     (cnt_done)
    );

    // Controller FSM with registered pad, receive and pending-read outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            rx_pend   <= 1'b0;
            burst_cnt <= '0;
            PAD_I     <= '0;
            PAD_T     <= 1'b1;
            RX_DATA   <= '0;
            RX_VALID  <= 1'b0;
        end else begin
            RX_VALID <= 1'b0;
            // Requests arriving during a capture are dropped.
            if (RX_REQ && (state != ST_CAPTURE)) begin
                rx_pend <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (rx_pend) begin
                        // Entering CAPTURE clears the pending read, unless a
                        // new request lands in this same cycle.
                        state   <= ST_CAPTURE;
                        rx_pend <= RX_REQ;
                    end else if (tx_fire) begin
                        state     <= ST_DRIVE;
                        PAD_I     <= TX_DATA;
                        PAD_T     <= 1'b0;
                        burst_cnt <= BURST_W'(1);
                    end
                end
                ST_DRIVE: begin
                    if (tx_fire) begin
                        PAD_I <= TX_DATA;
                        if (burst_cnt != BURST_SAT) begin
                            burst_cnt <= burst_cnt + BURST_W'(1);
                        end
                    end else begin
                        state <= ST_TURN;
                        PAD_T <= 1'b1;
                    end
                end
                ST_TURN: begin
                    if (cnt_done) begin
                        state     <= ST_IDLE;
                        burst_cnt <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (cnt_done) begin
                        state    <= ST_TURN;
                        RX_DATA  <= PAD_O;
                        RX_VALID <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign BUSY      = (state != ST_IDLE) || rx_pend;
    assign DBG_STATE = state;

endmodule

// File: doc/sstl_bidir_ctrl.md
Name: sstl_bidir_ctrl

Overview:
- Half-duplex controller that sits on the fabric side of a parameterised-width SSTL3 class II DCI bidirectional pad buffer.
- Generates the buffer's data (I) and tristate enable (T), and samples its receive path (O).
- Transmit words arrive on a valid/ready stream. Receive captures are requested by a single-cycle pulse.
- Enforces bus-turnaround gaps so the pad never drives against an external driver.

Parameters:
- WIDTH, 8, data width of pad bus and both streams.
- TURN_CYC, 2, hi-Z cycles inserted after any DRIVE or CAPTURE phase; legal range 1..15.
- SAMPLE_DLY, 3, cycles in CAPTURE before PAD_O is sampled (external device latency); legal range 1..15.
- MAX_BURST, 16, max consecutive words driven while a receive is pending; legal range 1..255.

Ports:
- CLK, input, 1, sole clock; all state on rising edge.
- RST, input, 1, asynchronous, active-high reset.
- TX_DATA, input, WIDTH, word to drive.
- TX_VALID, input, 1, TX_DATA valid.
- TX_READY, output, 1, word accepted when TX_VALID and TX_READY are both high.
- RX_REQ, input, 1, single-cycle pulse requesting one capture.
- RX_DATA, output, WIDTH, captured word.
- RX_VALID, output, 1, one-cycle pulse; RX_DATA is valid.
- PAD_I, output, WIDTH, to buffer I.
- PAD_T, output, 1, to buffer T; 1 = hi-Z.
- PAD_O, input, WIDTH, from buffer O.
- BUSY, output, 1, high in any state other than IDLE, or while a receive is pending.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-DRIVE):
  - PAD_T=1, PAD_I=0, RX_DATA=0, RX_VALID=0, BUSY=0.
  - State IDLE; rx_pend, burst count and turn counter cleared.
  - TX_READY=0 while RST is high.
- States: IDLE, DRIVE, TURN, CAPTURE. PAD_T=0 only in DRIVE; all other states hi-Z.
- rx_pend:
  - Set by RX_REQ; cleared on entry to CAPTURE.
  - An RX_REQ while rx_pend=1, or while in CAPTURE, is dropped with no queueing.
  - An RX_REQ in the same cycle that rx_pend clears sets it again.
- IDLE:
  - If rx_pend=1: TX_READY=0; go to CAPTURE next cycle. Receive has priority.
  - Else TX_READY=1. On handshake: next cycle DRIVE, PAD_I=TX_DATA, PAD_T=0, burst count=1.
  - Driving from IDLE needs no gap, because IDLE is only reached via TURN or reset.
- DRIVE:
  - TX_READY=1 unless (rx_pend=1 and burst count ≥ MAX_BURST).
  - On handshake: PAD_I updates next cycle, stay in DRIVE, burst count +1 (saturates at 255).
  - Otherwise: next cycle TURN, PAD_T=1, PAD_I holds last value.
  - Latency from handshake to word on pad: 1 cycle. Back-to-back words: 1 per cycle.
- TURN:
  - Occupies exactly TURN_CYC cycles, then IDLE.
  - TX_READY=0 throughout. Burst count cleared on exit.
- CAPTURE:
  - Occupies exactly SAMPLE_DLY cycles.
  - On the last cycle's edge, RX_DATA <= PAD_O.
  - The following cycle: RX_VALID=1 for one cycle, state=TURN.
  - RX_DATA holds its value until the next capture.
- Simultaneous events:
  - RX_REQ in the same cycle as a TX handshake in IDLE: the TX word wins that cycle. The read is served after the current burst ends, or after MAX_BURST words.
  - TX_VALID may deassert at any time without error.
- Counters are 4-bit (turn/sample) and 8-bit (burst). No wrap in legal ranges.

Decomposition:
- Shared package sstl_bidir_pkg holds:
  - state enum (IDLE=0, DRIVE=1, TURN=2, CAPTURE=3);
  - the counter widths (4 and 8);
  - the parameter range limits, checked by elaboration-time assertions.
- One sub-module, sstl_bidir_cnt: a loadable 4-bit down-counter with a done flag, shared by TURN and CAPTURE.

Test Plan:
- Reset mid-burst: RST high while PAD_T=0 -> PAD_T=1 in the same cycle (before the next edge); after release, TX_READY=1 and state IDLE.
- 3-word burst A5,5A,FF with TX_VALID held -> PAD_T=0 for exactly 3 cycles carrying A5,5A,FF starting 1 cycle after the first handshake; then 2 hi-Z TURN cycles with TX_READY=0.
- RX_REQ pulse in IDLE, PAD_O=3C -> CAPTURE for 3 cycles, RX_VALID pulses 1 cycle with RX_DATA=3C, 2 TURN cycles, back to IDLE; PAD_T=1 throughout.
- Continuous TX_VALID with RX_REQ at word 2 and MAX_BURST=16 -> TX_READY drops after the 16th word; TURN(2), IDLE(1), CAPTURE(3), RX_VALID, TURN(2); driving then resumes.
- Second RX_REQ while pending -> exactly one RX_VALID produced.
- RX_REQ and TX handshake in the same IDLE cycle -> word driven first; capture follows after TURN.
